// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory access sequencer.
// Consumed by mem_access_ctrl and mem_timeout_ctr.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    function automatic int ctr_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/ack bus between the access sequencer and unified memory.
// master drives the request, slave returns ack and read data.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_timeout.sv
// BUSY-cycle watchdog: expired flags the last cycle a request may
// wait for its ack (count == TIMEOUT-1).
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = ctr_w(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns level-held fetch/load/store intents into one valid/ack memory
// transaction each; optional alignment trap via MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_rd,
    input  logic              acc_wr,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              bus_err,
    mem_access_ctrl_if.master mem
);

    state_t            state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_any;
    logic              expired;
    logic              busy;

    assign req_any = acc_rd | acc_wr;
    assign busy    = (state == BUSY);
    assign stall   = ((state == IDLE) & req_any) | busy;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (acc_addr[1:0] != 2'b00);
`endif

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == IDLE) & req_any),
        .enable  (busy & ~mem.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rdata_vld <= 1'b0;
                    if (req_any) begin
                        // conflicting intents: the write is issued
                        if (acc_rd & acc_wr) begin
                            bus_err <= 1'b1;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        if (misaligned) begin
                            state     <= DONE;
                            bus_err   <= 1'b1;
                            rdata_vld <= ~acc_wr;
                        end else begin
                            state   <= BUSY;
                            req_q   <= 1'b1;
                            we_q    <= acc_wr;
                            addr_q  <= acc_addr;
                            wdata_q <= acc_wdata;
                        end
`else
                        state   <= BUSY;
                        req_q   <= 1'b1;
                        we_q    <= acc_wr;
                        addr_q  <= acc_addr;
                        wdata_q <= acc_wdata;
`endif
                    end
                end
                BUSY: begin
                    // ack beats a simultaneous timeout
                    if (mem.mem_ack) begin
                        state     <= DONE;
                        req_q     <= 1'b0;
                        rdata_vld <= ~we_q;
                        if (!we_q) begin
                            rdata <= mem.mem_rdata;
                        end
                    end else if (expired) begin
                        state     <= DONE;
                        req_q     <= 1'b0;
                        bus_err   <= 1'b1;
                        rdata_vld <= ~we_q;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rdata_vld <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl (table plus corner sequences).
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        acc_rd;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_vld;
    logic        bus_err;

    int total;
    int bad;
    int req_rises;
    logic prev_req;

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_access_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_rd    (acc_rd),
        .acc_wr    (acc_wr),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .stall     (stall),
        .rdata     (rdata),
        .rdata_vld (rdata_vld),
        .bus_err   (bus_err),
        .mem       (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            prev_req <= 1'b0;
        end else begin
            if (mif.mem_req && !prev_req) req_rises <= req_rises + 1;
            prev_req <= mif.mem_req;
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] mrd;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_vld;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rd, input logic wr,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic ack, input logic [31:0] mrd,
        input logic e_stall, input logic e_req, input logic e_we,
        input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic [31:0] e_rdata, input logic e_vld, input logic e_err
    );
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.ack = ack; v.mrd = mrd;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        v.e_vld = e_vld; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        acc_rd = 0; acc_wr = 0; acc_addr = 0; acc_wdata = 0;
        mif.mem_ack = 0; mif.mem_rdata = 0;
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            tick();
            acc_rd = vecs[i].rd;
            acc_wr = vecs[i].wr;
            acc_addr = vecs[i].addr;
            acc_wdata = vecs[i].wdata;
            mif.mem_ack = vecs[i].ack;
            mif.mem_rdata = vecs[i].mrd;
            #1;
            check($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            check($sformatf("v%0d_req", i), mif.mem_req, vecs[i].e_req);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
            check($sformatf("v%0d_vld", i), rdata_vld, vecs[i].e_vld);
            check($sformatf("v%0d_err", i), bus_err, vecs[i].e_err);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i), mif.mem_we, vecs[i].e_we);
                check($sformatf("v%0d_addr", i), mif.mem_addr, vecs[i].e_addr);
                check($sformatf("v%0d_wdata", i), mif.mem_wdata, vecs[i].e_wdata);
            end
        end
    endtask

    initial begin
        int nreq;
        int nstall;
        total = 0;
        bad = 0;
        req_rises = 0;
        reset = 1;
        idle_in();

        // read, ack in first BUSY cycle
        vecs.push_back(mk(1,0,32'h4,0,0,0,                1,0,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,32'h4,0,1,32'h2002000A,     1,1,0,32'h4,0, 0,0,0));
        vecs.push_back(mk(1,0,32'h4,0,0,0,                0,0,0,0,0, 32'h2002000A,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,                    0,0,0,0,0, 32'h2002000A,0,0));
        // write, ack in fifth BUSY cycle
        vecs.push_back(mk(0,1,32'h54,7,0,0,               1,0,0,0,0, 32'h2002000A,0,0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,1,32'h54,7,0,0,           1,1,1,32'h54,7, 32'h2002000A,0,0));
        vecs.push_back(mk(0,1,32'h54,7,1,32'hDEADBEEF,    1,1,1,32'h54,7, 32'h2002000A,0,0));
        vecs.push_back(mk(0,1,32'h54,7,0,0,               0,0,0,0,0, 32'h2002000A,0,0));
        // stray ack in IDLE
        vecs.push_back(mk(0,0,0,0,1,32'h11111111,         0,0,0,0,0, 32'h2002000A,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                    0,0,0,0,0, 32'h2002000A,0,0));
        // back-to-back fetch then load
        vecs.push_back(mk(1,0,32'h100,0,0,0,              1,0,0,0,0, 32'h2002000A,0,0));
        vecs.push_back(mk(1,0,32'h100,0,1,32'h11,         1,1,0,32'h100,0, 32'h2002000A,0,0));
        vecs.push_back(mk(1,0,32'h100,0,0,0,              0,0,0,0,0, 32'h11,1,0));
        vecs.push_back(mk(1,0,32'h200,0,0,0,              1,0,0,0,0, 32'h11,0,0));
        vecs.push_back(mk(1,0,32'h200,0,0,0,              1,1,0,32'h200,0, 32'h11,0,0));
        vecs.push_back(mk(1,0,32'h200,0,1,32'h22,         1,1,0,32'h200,0, 32'h11,0,0));
        vecs.push_back(mk(1,0,32'h200,0,0,0,              0,0,0,0,0, 32'h22,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,                    0,0,0,0,0, 32'h22,0,0));
        // read and write together: write issued, error set
        vecs.push_back(mk(1,1,32'h300,32'h33,0,0,         1,0,0,0,0, 32'h22,0,0));
        vecs.push_back(mk(1,1,32'h300,32'h33,1,32'h55,    1,1,1,32'h300,32'h33, 32'h22,0,1));
        vecs.push_back(mk(1,1,32'h300,32'h33,0,0,         0,0,0,0,0, 32'h22,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,                    0,0,0,0,0, 32'h22,0,1));

        #12;
        check("rst_req", mif.mem_req, 0);
        check("rst_we", mif.mem_we, 0);
        check("rst_addr", mif.mem_addr, 0);
        check("rst_wdata", mif.mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_vld", rdata_vld, 0);
        check("rst_err", bus_err, 0);
        check("rst_stall", stall, 0);
        @(posedge clk);
        #1 reset = 0;

        run_table();
        tick();
        check("req_rises", req_rises, 5);

        // reset in BUSY, then a late ack
        acc_rd = 1; acc_addr = 32'h40;
        #1 check("rb_stall", stall, 1);
        tick();
        check("rb_req", mif.mem_req, 1);
        check("rb_addr", mif.mem_addr, 32'h40);
        #2;
        reset = 1;
        acc_rd = 0;
        #1;
        check("rb_req0", mif.mem_req, 0);
        check("rb_addr0", mif.mem_addr, 0);
        check("rb_wdata0", mif.mem_wdata, 0);
        check("rb_rdata0", rdata, 0);
        check("rb_err0", bus_err, 0);
        check("rb_vld0", rdata_vld, 0);
        check("rb_stall0", stall, 0);
        tick();
        reset = 0;
        mif.mem_ack = 1; mif.mem_rdata = 32'h99;
        tick();
        mif.mem_ack = 0;
        #1;
        check("late_req", mif.mem_req, 0);
        check("late_rdata", rdata, 0);
        check("late_vld", rdata_vld, 0);
        check("late_stall", stall, 0);
        tick();
        check("late_vld2", rdata_vld, 0);

        // no ack: timeout after 16 BUSY cycles
        acc_rd = 1; acc_addr = 32'h80;
        #1;
        nreq = 0;
        nstall = stall ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mif.mem_req) nreq++;
            if (stall) nstall++;
            if (!mif.mem_req) break;
        end
        check("to_busy_cycles", nreq, 16);
        check("to_stall_cycles", nstall, 17);
        check("to_err", bus_err, 1);
        check("to_vld", rdata_vld, 1);
        check("to_rdata", rdata, 0);
        check("to_stall", stall, 0);
        acc_rd = 0;
        tick();
        tick();
        check("to_err_sticky", bus_err, 1);
        acc_rd = 1; acc_addr = 32'h84;
        tick();
        mif.mem_ack = 1; mif.mem_rdata = 32'hCAFE0001;
        #1 check("post_req", mif.mem_req, 1);
        tick();
        mif.mem_ack = 0;
        #1;
        check("post_vld", rdata_vld, 1);
        check("post_rdata", rdata, 32'hCAFE0001);
        check("post_err", bus_err, 1);
        acc_rd = 0;
        tick();

        // misaligned read at 0x6
        #2 reset = 1;
        #3 reset = 0;
        tick();
        acc_rd = 1; acc_addr = 32'h6;
        #1 check("al_stall", stall, 1);
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        check("al_req", mif.mem_req, 0);
        check("al_vld", rdata_vld, 1);
        check("al_err", bus_err, 1);
        check("al_rdata", rdata, 0);
        check("al_stall_done", stall, 0);
`else
        check("al_req", mif.mem_req, 1);
        check("al_addr", mif.mem_addr, 32'h6);
        check("al_err", bus_err, 0);
        mif.mem_ack = 1; mif.mem_rdata = 32'h66;
        tick();
        mif.mem_ack = 0;
        #1;
        check("al_vld", rdata_vld, 1);
        check("al_rdata", rdata, 32'h66);
        check("al_err_done", bus_err, 0);
`endif
        acc_rd = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
